// File: rtl/pwm_count_consumer.sv
// Turns a free-running counter value into a registered PWM output with a
// wrap-synchronised duty buffer, per-period wrap pulse/count and sequence checking.
module pwm_count_consumer #(
    parameter int WIDTH = 4,
    parameter int PCW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_load,
    input  logic             en,
    input  logic             err_clr,
    output logic             pwm_out,
    output logic             wrap_pulse,
    output logic [PCW-1:0]   period_cnt,
    output logic             seq_err
);

    logic [WIDTH-1:0] prev_cnt;
    logic             prev_vld;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] duty_pend;
    logic             pend_vld;

    logic [WIDTH-1:0] cnt_succ;
    logic             wrap;
    logic             seq_bad;
    logic [WIDTH-1:0] duty_eff;
    logic [WIDTH-1:0] duty_pend_nx;
    logic             pend_vld_nx;

    assign cnt_succ = prev_cnt + 1'b1;
    assign wrap     = prev_vld && (prev_cnt == {WIDTH{1'b1}}) && (cnt_in == '0);
    assign seq_bad  = prev_vld && (cnt_in != cnt_succ);

    // duty_eff is the active duty after this edge, so a wrap cycle already
    // compares against the newly applied value.
    always_comb begin
        duty_eff     = duty_act;
        duty_pend_nx = duty_pend;
        pend_vld_nx  = pend_vld;
        if (wrap) begin
            if (duty_load) begin
                duty_eff = duty_in;
            end else if (pend_vld) begin
                duty_eff = duty_pend;
            end
            pend_vld_nx = 1'b0;
        end else if (duty_load) begin
            duty_pend_nx = duty_in;
            pend_vld_nx  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cnt   <= '0;
            prev_vld   <= 1'b0;
            duty_act   <= '0;
            duty_pend  <= '0;
            pend_vld   <= 1'b0;
            pwm_out    <= 1'b0;
            wrap_pulse <= 1'b0;
            period_cnt <= '0;
            seq_err    <= 1'b0;
        end else begin
            prev_cnt   <= cnt_in;
            prev_vld   <= 1'b1;
            duty_act   <= duty_eff;
            duty_pend  <= duty_pend_nx;
            pend_vld   <= pend_vld_nx;
            pwm_out    <= en & (cnt_in < duty_eff);
            wrap_pulse <= wrap;
            if (wrap && en) begin
                period_cnt <= period_cnt + 1'b1;
            end
            // A new error outranks a simultaneous clear.
            if (seq_bad) begin
                seq_err <= 1'b1;
            end else if (err_clr) begin
                seq_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_count_consumer.sv
// Scoreboard bench for pwm_count_consumer: a behavioural model queues the
// expected outputs for every driven cycle and they are popped after the edge.
module tb_pwm_count_consumer;

    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic [3:0] duty_in;
    logic       duty_load;
    logic       en;
    logic       err_clr;
    logic       pwm_out;
    logic       wrap_pulse;
    logic [7:0] period_cnt;
    logic       seq_err;

    pwm_count_consumer #(.WIDTH(4), .PCW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .duty_in    (duty_in),
        .duty_load  (duty_load),
        .en         (en),
        .err_clr    (err_clr),
        .pwm_out    (pwm_out),
        .wrap_pulse (wrap_pulse),
        .period_cnt (period_cnt),
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pwm;
        logic       wrap;
        logic [7:0] pc;
        logic       err;
    } exp_t;

    exp_t q[$];

    int check_cnt = 0;
    int fail_cnt  = 0;
    int cur       = 0;
    int hi_acc    = 0;
    logic en_v    = 1'b1;

    // Reference model state, written from the behavioural description.
    int m_prev, m_act, m_pend, m_pc;
    bit m_pvld, m_pendv, m_err;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_act = 0; m_pend = 0; m_pc = 0;
        m_pvld = 0; m_pendv = 0; m_err = 0;
    endtask

    task automatic applyStimulus(input int c, input bit dl, input int dv, input bit clr);
        exp_t e;
        bit   is_wrap, is_bad;
        cnt_in    = c[3:0];
        duty_load = dl;
        duty_in   = dv[3:0];
        err_clr   = clr;
        en        = en_v;

        is_wrap = m_pvld && (m_prev == 15) && (c == 0);
        is_bad  = m_pvld && (c != ((m_prev + 1) % 16));
        if (is_wrap) begin
            if (dl) m_act = dv;
            else if (m_pendv) m_act = m_pend;
            m_pendv = 0;
        end else if (dl) begin
            m_pend  = dv;
            m_pendv = 1;
        end
        e.pwm  = en_v && (c < m_act);
        e.wrap = is_wrap;
        if (is_wrap && en_v) m_pc = (m_pc + 1) % 256;
        e.pc = m_pc[7:0];
        if (is_bad) m_err = 1;
        else if (clr) m_err = 0;
        e.err  = m_err;
        m_prev = c;
        m_pvld = 1;
        q.push_back(e);

        @(posedge clk);
        #1;
        e = q.pop_front();
        checkOutput("pwm_out", {31'b0, pwm_out}, {31'b0, e.pwm});
        checkOutput("wrap_pulse", {31'b0, wrap_pulse}, {31'b0, e.wrap});
        checkOutput("period_cnt", {24'b0, period_cnt}, {24'b0, e.pc});
        checkOutput("seq_err", {31'b0, seq_err}, {31'b0, e.err});
        if (pwm_out === 1'b1) hi_acc++;
        duty_load = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic run_free(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(cur, 1'b0, 0, 1'b0);
            cur = (cur + 1) % 16;
        end
    endtask

    task automatic load_at(input int dv);
        applyStimulus(cur, 1'b1, dv, 1'b0);
        cur = (cur + 1) % 16;
    endtask

    task automatic jump_to(input int c, input bit clr);
        applyStimulus(c, 1'b0, 0, clr);
        cur = (c + 1) % 16;
    endtask

    task automatic period_high(input int exp_hi);
        hi_acc = 0;
        run_free(16);
        checkOutput("period_high", hi_acc, exp_hi);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_pwm"}, {31'b0, pwm_out}, 32'd0);
        checkOutput({tag, "_wrap"}, {31'b0, wrap_pulse}, 32'd0);
        checkOutput({tag, "_pc"}, {24'b0, period_cnt}, 32'd0);
        checkOutput({tag, "_err"}, {31'b0, seq_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; cnt_in = '0; duty_in = '0; duty_load = 1'b0;
        en = 1'b1; err_clr = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        cur = 0;

        // First period runs at duty 0, load 5 before the first wrap.
        $display("[TB] basic duty 5");
        run_free(3);
        load_at(5);
        run_free(12);
        period_high(5);
        period_high(5);

        $display("[TB] duty 12 loaded mid-period");
        run_free(7);
        load_at(12);
        run_free(8);
        period_high(12);

        $display("[TB] last load wins");
        run_free(2);
        load_at(3);
        run_free(7);
        load_at(9);
        run_free(5);
        period_high(9);

        $display("[TB] load on wrap cycle");
        hi_acc = 0;
        load_at(0);
        run_free(15);
        checkOutput("duty0_high", hi_acc, 0);

        $display("[TB] full-scale duty and enable gating");
        run_free(4);
        load_at(15);
        run_free(11);
        period_high(15);
        run_free(5);
        en_v = 1'b0;
        run_free(20);
        en_v = 1'b1;
        run_free(7);

        $display("[TB] sequence errors");
        run_free(3);
        run_free(2);
        jump_to(9, 1'b0);
        run_free(6);
        jump_to(0, 1'b1);
        run_free(2);
        jump_to(7, 1'b1);
        run_free(3);
        jump_to(11, 1'b1);
        run_free(4);
        run_free(3);
        load_at(2);
        run_free(3);
        jump_to(0, 1'b0);
        run_free(15);
        period_high(2);

        $display("[TB] asynchronous reset mid-period");
        load_at(15);
        run_free(5);
        checkOutput("pre_reset_pwm", {31'b0, pwm_out}, 32'd1);
        rst = 1'b0;
        #2;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        jump_to(9, 1'b0);
        run_free(6);
        hi_acc = 0;
        run_free(16);
        checkOutput("post_reset_high", hi_acc, 0);
        run_free(1);
        load_at(7);
        run_free(14);
        period_high(7);

        checkOutput("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
